layer_loop_controller: RTL

LAYER_LOOP_CONTROLLER -- requirements
Module: layer_loop_controller

---
 rtl/layer_loop_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/layer_loop_controller.sv
// Layer loop sequencer: walks input-channel x output-channel-group passes
// for one conv layer, in either loop order, with a bubble between passes.
module layer_loop_controller #(
  parameter int ID_W   = 4,
  parameter int OD_W   = 8,
  parameter int DIM_W  = 9,
  parameter int BLK_W  = 8,
  parameter int OD_PAR = 2,
  parameter int TILE   = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cfg_we_i,
  input  logic [ID_W-1:0]              cfg_id_i,
  input  logic [OD_W-1:0]              cfg_od_i,
  input  logic [DIM_W-1:0]             cfg_width_i,
  input  logic [DIM_W-1:0]             cfg_height_i,
  input  logic                         cfg_size_type_i,
  input  logic                         cfg_od_outer_i,
  input  logic                         start_i,
  input  logic                         pass_done_i,
  output logic                         pass_valid_o,
  output logic [ID_W-1:0]              pass_id_o,
  output logic [OD_W-1:0]              pass_od_base_o,
  output logic [$clog2(OD_PAR+1)-1:0]  pass_od_cnt_o,
  output logic                         first_id_o,
  output logic                         last_id_o,
  output logic [BLK_W-1:0]             block_width_o,
  output logic [BLK_W-1:0]             block_height_o,
  output logic                         size_type_o,
  output logic                         busy_o,
  output logic                         conv_completed_o,
  output logic                         cfg_err_o
);

  localparam int CNT_W = $clog2(OD_PAR+1);
  localparam logic [OD_W:0] PAR = (OD_W+1)'(OD_PAR);
  localparam logic [32:0] BLK_MAX = (33'd1 << BLK_W) - 33'd1;

  typedef enum logic [1:0] {
    IDLE, RUN, STEP, DONE
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]  id_q;
  logic [OD_W-1:0]  od_q;
  logic [DIM_W-1:0] width_q;
  logic [DIM_W-1:0] height_q;
  logic             size_q;
  logic             order_q;
  logic [ID_W-1:0]  id_cnt_q;
  logic [OD_W-1:0]  od_base_q;

  logic [OD_W:0]    od_next;
  logic [OD_W-1:0]  od_left;
  logic             od_wrap;
  logic             id_last;
  logic             last_pass;
  logic             idle_like;
  logic             cfg_ld;
  logic             go;
  logic [31:0]      w_blk;
  logic [31:0]      h_blk;

  function automatic logic [31:0] blocks(input logic [DIM_W-1:0] d);
    logic [31:0] n;
    n = (32'(d) + 32'(TILE-1)) / 32'(TILE);
    return (n == 32'd0) ? 32'd1 : n;
  endfunction

  assign w_blk = blocks(width_q);
  assign h_blk = blocks(height_q);

  assign block_width_o  = w_blk[BLK_W-1:0];
  assign block_height_o = h_blk[BLK_W-1:0];
  assign size_type_o    = size_q;

  assign cfg_err_o = (id_q == '0) || (od_q == '0) ||
                     ({1'b0, w_blk} > BLK_MAX) ||
                     ({1'b0, h_blk} > BLK_MAX);

  // one extra bit so the group step never wraps at the top od value
  assign od_next   = {1'b0, od_base_q} + PAR;
  assign od_wrap   = od_next >= {1'b0, od_q};
  assign id_last   = id_cnt_q == (id_q - ID_W'(1));
  assign last_pass = id_last && od_wrap;

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign cfg_ld    = cfg_we_i && idle_like;
  assign go        = start_i && !cfg_we_i && idle_like;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (cfg_ld)  state_d = IDLE;
        else if (go) state_d = cfg_err_o ? DONE : RUN;
      end
      RUN: begin
        if (pass_done_i) state_d = last_pass ? DONE : STEP;
      end
      STEP:    state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pass_valid_o     = 1'b0;
    busy_o           = 1'b0;
    conv_completed_o = 1'b0;
    case (state_q)
      RUN: begin
        pass_valid_o = 1'b1;
        busy_o       = 1'b1;
      end
      STEP:    busy_o = 1'b1;
      DONE:    conv_completed_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_q     <= '0;
      od_q     <= '0;
      width_q  <= '0;
      height_q <= '0;
      size_q   <= 1'b0;
      order_q  <= 1'b0;
    end else if (cfg_ld) begin
      id_q     <= cfg_id_i;
      od_q     <= cfg_od_i;
      width_q  <= cfg_width_i;
      height_q <= cfg_height_i;
      size_q   <= cfg_size_type_i;
      order_q  <= cfg_od_outer_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_cnt_q  <= '0;
      od_base_q <= '0;
    end else if (go) begin
      id_cnt_q  <= '0;
      od_base_q <= '0;
    end else if (state_q == STEP) begin
      if (!order_q) begin
        if (od_wrap) begin
          od_base_q <= '0;
          id_cnt_q  <= id_cnt_q + ID_W'(1);
        end else begin
          od_base_q <= od_next[OD_W-1:0];
        end
      end else begin
        if (id_last) begin
          id_cnt_q  <= '0;
          od_base_q <= od_next[OD_W-1:0];
        end else begin
          id_cnt_q  <= id_cnt_q + ID_W'(1);
        end
      end
    end
  end

  assign od_left        = od_q - od_base_q;
  assign pass_id_o      = id_cnt_q;
  assign pass_od_base_o = od_base_q;
  assign first_id_o     = id_cnt_q == '0;
  assign last_id_o      = id_last;

  always_comb begin
    pass_od_cnt_o = CNT_W'(od_left);
    if (32'(od_left) >= 32'(OD_PAR)) pass_od_cnt_o = CNT_W'(OD_PAR);
  end

endmodule
